// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter.
// Holds the arbiter FSM state encoding, the default TX register address and the byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] UART_TX_ADDR_DEF = 3'b100;
  localparam int         BYTE_W           = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first asserted request at or above pointer, wrapping past N_REQ-1 to 0.
// Latency: purely combinational. Backpressure: none; the caller samples idx/valid when it is ready.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(pointer) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between N_REQ byte producers, with a tx_done watchdog.
// Latency: req sampled in IDLE -> uart_wr/gnt next cycle. Backpressure: requesters hold req until gnt.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter logic [2:0] UART_TX_ADDR = UART_TX_ADDR_DEF,
  parameter int         TIMEOUT_CYC  = 2048
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [BYTE_W-1:0]         uart_data,
  output logic [2:0]                uart_addr,
  output logic                      uart_wr,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int               IDX_W   = $clog2(N_REQ);
  localparam int               WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [IDX_W-1:0]   pointer;
  logic [IDX_W-1:0]   idx;
  logic [WD_W-1:0]    watchdog;

  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [BYTE_W-1:0]  sel_byte;
  logic [N_REQ-1:0]   arb_onehot;
  logic [N_REQ-1:0]   idx_onehot;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req),
    .pointer (pointer),
    .idx     (arb_idx),
    .valid   (arb_vld)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) sel_byte = req_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign arb_onehot = N_REQ'(1) << arb_idx;
  assign idx_onehot = N_REQ'(1) << idx;
  // The requester just served drops to lowest priority for the next round.
  assign next_ptr   = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pointer     <= '0;
      idx         <= '0;
      watchdog    <= '0;
      gnt         <= '0;
      done        <= '0;
      uart_data   <= '0;
      uart_addr   <= 3'b000;
      uart_wr     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt         <= '0;
      done        <= '0;
      uart_wr     <= 1'b0;
      uart_addr   <= 3'b000;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            state     <= LOAD;
            idx       <= arb_idx;
            uart_data <= sel_byte;
            uart_wr   <= 1'b1;
            uart_addr <= UART_TX_ADDR;
            gnt       <= arb_onehot;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state    <= WAIT;
          watchdog <= '0;
        end
        WAIT: begin
          // tx_done takes precedence over a watchdog expiring in the same cycle.
          if (tx_done) begin
            state   <= DONE;
            done    <= idx_onehot;
            pointer <= next_ptr;
          end else if (watchdog == WD_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            pointer     <= next_ptr;
            busy        <= 1'b0;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter: a transfer-level model predicts each
// grant/done/timeout with its cycle; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int T        = 16;
  localparam int RUN_CYC  = 4000;
  localparam int TAIL     = 300;
  localparam int MAXC     = 8000;
  localparam int K_GNT    = 0;
  localparam int K_DONE   = 1;
  localparam int K_TO     = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     uart_data;
  logic [2:0]     uart_addr;
  logic           uart_wr;
  logic           tx_done;
  logic           busy;
  logic           timeout_err;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .UART_TX_ADDR (3'b100),
    .TIMEOUT_CYC  (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .uart_data   (uart_data),
    .uart_addr   (uart_addr),
    .uart_wr     (uart_wr),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         cyc;
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  bit         busy_exp [0:MAXC-1];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [7:0] cur_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle compare busy, idle address and any event against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missed_event", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      check("busy", busy, busy_exp[cyc]);
      if (!uart_wr) check("addr_idle", uart_addr, 3'b000);
      if (busy && !uart_wr) check("data_hold", uart_data, cur_data);
      if (uart_wr || gnt != 0 || done != 0 || timeout_err) begin
        if (q.size() == 0) begin
          check("unexpected_event", {gnt, done, uart_wr, timeout_err}, 0);
        end else begin
          e = q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          case (e.kind)
            K_GNT: begin
              check("gnt", gnt, 4'b0001 << e.idx);
              check("uart_wr", uart_wr, 1'b1);
              check("uart_data", uart_data, e.data);
              check("uart_addr", uart_addr, 3'b100);
              check("done_in_load", done, 0);
              cur_data = e.data;
            end
            K_DONE: begin
              check("done", done, 4'b0001 << e.idx);
              check("timeout_in_done", timeout_err, 1'b0);
              check("wr_in_done", uart_wr, 1'b0);
            end
            default: begin
              check("timeout_err", timeout_err, 1'b1);
              check("done_on_timeout", done, 0);
              check("gnt_on_timeout", gnt, 0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, w, j, d, nidle, r;
    int ptr_m, idle_from, txd_cyc, load_cyc, win_m;
    bit pend [N];

    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_uart_data", uart_data, 0);
    check("rst_uart_addr", uart_addr, 0);
    check("rst_uart_wr", uart_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;

    // One transfer, tx_done pulsed in LOAD (must be ignored), then reset mid-WAIT
    @(posedge clk); #1;
    req = 4'b0010; req_data[15:8] = 8'h55;
    @(posedge clk); #1;
    req = '0; tx_done = 1'b1;
    @(negedge clk);
    check("dir_wr", uart_wr, 1'b1);
    check("dir_gnt", gnt, 4'b0010);
    check("dir_data", uart_data, 8'h55);
    check("dir_addr", uart_addr, 3'b100);
    @(posedge clk); #1; tx_done = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("dir_load_txdone_ignored_busy", busy, 1'b1);
    check("dir_load_txdone_ignored_done", done, 0);
    rst = 1'b1; #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", uart_data, 8'h00);
    @(posedge clk); #1;
    check("midrst_all", {gnt, done, uart_wr, uart_addr, timeout_err}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stale_txdone_no_done", done, 0);
      check("stale_txdone_idle", busy, 1'b0);
    end

    // Randomised phase against the transfer-level model
    ptr_m = 0; txd_cyc = -1; load_cyc = -1; win_m = 0;
    @(posedge clk); #1;
    idle_from = cyc;
    mon_en = 1'b1;
    for (int n = 0; n < RUN_CYC; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      c = cyc;
      tx_done = (c == txd_cyc);
      if (c == load_cyc) begin
        if (n < RUN_CYC - TAIL && $urandom_range(0, 1) == 1) begin
          req_data[8*win_m +: 8] = 8'($urandom);
        end else begin
          req[win_m] = 1'b0;
          pend[win_m] = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
      end
      if (c >= idle_from && $urandom_range(0, 7) == 0) tx_done = 1'b1;
      if (n == 0) begin
        req = 4'b0100; req_data[23:16] = 8'hAA; pend[2] = 1'b1;
      end else if (n < RUN_CYC - TAIL) begin
        r = $urandom_range(0, 3);
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 5) <= ((r == 0) ? 5 : 0)) begin
            req[i] = 1'b1; req_data[8*i +: 8] = 8'($urandom); pend[i] = 1'b1;
          end
        end
      end
      if (c >= idle_from && req != 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (w < 0 && req[j]) w = j;
        end
        q.push_back('{K_GNT, c + 1, w, req_data[8*w +: 8]});
        r = $urandom_range(0, 9);
        if (r <= 5)      d = $urandom_range(0, T - 2);
        else if (r == 6) d = T - 1;
        else if (r == 7) d = T - 2;
        else             d = T;
        if (n == 0) d = 10;
        if (d < T) begin
          txd_cyc = c + 2 + d;
          q.push_back('{K_DONE, c + 3 + d, w, 8'h00});
          nidle = c + 4 + d;
        end else begin
          txd_cyc = -1;
          q.push_back('{K_TO, c + 2 + T, w, 8'h00});
          nidle = c + 2 + T;
        end
        for (int x = c + 1; x < nidle; x++) busy_exp[x] = 1'b1;
        ptr_m = (w + 1) % N;
        win_m = w;
        load_cyc = c + 1;
        idle_from = nidle;
      end
    end
    repeat (T + 8) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
